// File: rtl/aes_mode_engine.sv
// rtl/aes_mode_engine.sv - ECB/CBC/CTR block-chaining controller in front of a single-block AES core
//
// Purpose : streams 128-bit blocks of a message through an external one-shot AES
//           core, applying ECB, CBC or CTR chaining, and buffers results in an
//           output FIFO with valid/ready backpressure.
// Ports   : clk, srst_n (async, active-low)
//           start, mode_sel, dir, key, iv      - message setup (sampled in IDLE)
//           in_valid/in_ready/in_last/in_word  - input block stream
//           out_valid/out_ready/out_last/out_word - output block stream (FIFO head)
//           busy, done, err                    - message status
//           core_enable/core_mode/core_key/core_word, core_result/core_done - AES core
// Macro   : AES_MODE_CTR_EN - builds CTR mode and its counter; otherwise mode_sel=2 is rejected.
module aes_mode_engine #(
   parameter int KEY_BW    = 256,
   parameter int TXT_BW    = 128,
   parameter int OUT_DEPTH = 4,
   parameter int CNT_BW    = 32
) (
   input  logic              clk,
   input  logic              srst_n,
   input  logic              start,
   input  logic [1:0]        mode_sel,
   input  logic              dir,
   input  logic [KEY_BW-1:0] key,
   input  logic [TXT_BW-1:0] iv,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_last,
   input  logic [TXT_BW-1:0] in_word,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic [TXT_BW-1:0] out_word,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              core_enable,
   output logic              core_mode,
   output logic [KEY_BW-1:0] core_key,
   output logic [TXT_BW-1:0] core_word,
   input  logic [TXT_BW-1:0] core_result,
   input  logic              core_done
);

   localparam int AW = $clog2(OUT_DEPTH);
   localparam logic [1:0]    MODE_ECB = 2'd0;
   localparam logic [1:0]    MODE_CBC = 2'd1;
   localparam logic [1:0]    MODE_CTR = 2'd2;
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(OUT_DEPTH);

   if (OUT_DEPTH < 2 || (1 << AW) != OUT_DEPTH) begin : g_bad_depth
      $error("OUT_DEPTH must be a power of 2 and at least 2");
   end
   if (CNT_BW < 1 || CNT_BW >= TXT_BW) begin : g_bad_cnt_bw
      $error("CNT_BW must lie in 1..TXT_BW-1");
   end

   typedef enum logic [2:0] {S_IDLE, S_GET, S_KICK, S_WAIT, S_PUSH} state_t;

   state_t              state_q;
   logic [1:0]          mode_q;
   logic                dir_q;
   logic                last_q;
   logic [TXT_BW-1:0]   chain_q;
   logic [TXT_BW-1:0]   blk_q;
   logic [TXT_BW-1:0]   res_q;
   logic [KEY_BW-1:0]   key_q;
   logic [TXT_BW-1:0]   core_word_q;
   logic                busy_q, in_ready_q, core_enable_q, core_mode_q, done_q, err_q;
`ifdef AES_MODE_CTR_EN
   localparam logic [CNT_BW-1:0] CTR_ONE = CNT_BW'(1);
   logic [TXT_BW-1:0]   ctr_q;
`endif

   logic [TXT_BW-1:0]   mem_q [OUT_DEPTH];
   logic [OUT_DEPTH-1:0] last_mem_q;
   logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
   logic [AW:0]         cnt_q;

   logic                mode_ok;
   logic [TXT_BW-1:0]   core_word_d;
   logic [TXT_BW-1:0]   res_d;
   logic                full, pop, push;

   assign full      = (cnt_q == CNT_FULL);
   assign out_valid = (cnt_q != '0);
   assign pop       = out_valid && out_ready;
   // A full FIFO still accepts a push in the same cycle as a pop.
   assign push      = (state_q == S_PUSH) && (!full || pop);

   assign out_word    = mem_q[rd_ptr_q];
   assign out_last    = last_mem_q[rd_ptr_q];
   assign in_ready    = in_ready_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign err         = err_q;
   assign core_enable = core_enable_q;
   assign core_mode   = core_mode_q;
   assign core_key    = key_q;
   assign core_word   = core_word_q;

   always_comb begin
      mode_ok = (mode_sel == MODE_ECB) || (mode_sel == MODE_CBC);
`ifdef AES_MODE_CTR_EN
      if (mode_sel == MODE_CTR) mode_ok = 1'b1;
`endif
   end

   // Block presented to the core, computed as the input block is accepted.
   always_comb begin
      core_word_d = in_word;
      if (mode_q == MODE_CBC && !dir_q) core_word_d = in_word ^ chain_q;
`ifdef AES_MODE_CTR_EN
      if (mode_q == MODE_CTR) core_word_d = ctr_q;
`endif
   end

   // Output block derived from the core result.
   always_comb begin
      res_d = core_result;
      if (mode_q == MODE_CBC && dir_q) res_d = core_result ^ chain_q;
`ifdef AES_MODE_CTR_EN
      if (mode_q == MODE_CTR) res_d = core_result ^ blk_q;
`endif
   end

   always_ff @(posedge clk or negedge srst_n) begin
      if (!srst_n) begin
         state_q       <= S_IDLE;
         mode_q        <= '0;
         dir_q         <= 1'b0;
         last_q        <= 1'b0;
         chain_q       <= '0;
         blk_q         <= '0;
         res_q         <= '0;
         key_q         <= '0;
         core_word_q   <= '0;
         busy_q        <= 1'b0;
         in_ready_q    <= 1'b0;
         core_enable_q <= 1'b0;
         core_mode_q   <= 1'b0;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
`ifdef AES_MODE_CTR_EN
         ctr_q         <= '0;
`endif
      end else begin
         done_q        <= 1'b0;
         core_enable_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  if (mode_ok) begin
                     err_q       <= 1'b0;
                     mode_q      <= mode_sel;
                     dir_q       <= dir;
                     key_q       <= key;
                     chain_q     <= iv;
                     core_mode_q <= (mode_sel == MODE_CTR) ? 1'b0 : dir;
                     busy_q      <= 1'b1;
                     in_ready_q  <= 1'b1;
                     state_q     <= S_GET;
`ifdef AES_MODE_CTR_EN
                     ctr_q       <= iv;
`endif
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            S_GET: begin
               if (in_valid) begin
                  blk_q         <= in_word;
                  last_q        <= in_last;
                  core_word_q   <= core_word_d;
                  in_ready_q    <= 1'b0;
                  core_enable_q <= 1'b1;
                  state_q       <= S_KICK;
               end
            end
            S_KICK: state_q <= S_WAIT;
            S_WAIT: begin
               if (core_done) begin
                  res_q   <= res_d;
                  state_q <= S_PUSH;
                  // Encrypt chains on the ciphertext produced, decrypt on the ciphertext consumed.
                  if (mode_q == MODE_CBC) chain_q <= dir_q ? blk_q : core_result;
`ifdef AES_MODE_CTR_EN
                  if (mode_q == MODE_CTR)
                     ctr_q <= {ctr_q[TXT_BW-1:CNT_BW], ctr_q[CNT_BW-1:0] + CTR_ONE};
`endif
               end
            end
            S_PUSH: begin
               if (push) begin
                  if (last_q) begin
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= S_IDLE;
                  end else begin
                     in_ready_q <= 1'b1;
                     state_q    <= S_GET;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge srst_n) begin
      if (!srst_n) begin
         for (int i = 0; i < OUT_DEPTH; i++) mem_q[i] <= '0;
         last_mem_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q]      <= res_q;
            last_mem_q[wr_ptr_q] <= last_q;
            wr_ptr_q             <= wr_ptr_q + PTR_ONE;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + CNT_ONE;
            2'b01:   cnt_q <= cnt_q - CNT_ONE;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_mode_engine.sv
// tb/tb_aes_mode_engine.sv - directed self-checking bench for aes_mode_engine with a stub AES core
`timescale 1ns/1ps
module tb_aes_mode_engine;

   localparam logic [255:0] K   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT0 = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] IVC = 128'h0123456789abcdef01234567ffffffff;
   localparam logic [127:0] W1C = 128'h0123456789abcdef0123456700000000;
   localparam logic [127:0] P1  = 128'hdeadbeef0badf00dcafebabe12345678;
   localparam logic [127:0] P2  = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

   logic         clk = 1'b0;
   logic         srst_n;
   logic         start;
   logic [1:0]   mode_sel;
   logic         dir;
   logic [255:0] key;
   logic [127:0] iv;
   logic         in_valid, in_ready, in_last;
   logic [127:0] in_word;
   logic         out_valid, out_ready, out_last;
   logic [127:0] out_word;
   logic         busy, done, err;
   logic         core_enable, core_mode;
   logic [255:0] core_key;
   logic [127:0] core_word;
   logic [127:0] core_result;
   logic         core_done;

   int passed = 0;
   int total  = 0;
   int done_cnt = 0;
   int exp_done = 0;
   logic [127:0] word_log [$];
   logic         mode_log [$];
   logic [127:0] stub_w;
   logic         stub_m;
   logic [127:0] cb0, cb1;

   always #5 clk = ~clk;

   aes_mode_engine dut (
      .clk(clk), .srst_n(srst_n), .start(start), .mode_sel(mode_sel), .dir(dir),
      .key(key), .iv(iv), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
      .in_word(in_word), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
      .out_word(out_word), .busy(busy), .done(done), .err(err),
      .core_enable(core_enable), .core_mode(core_mode), .core_key(core_key),
      .core_word(core_word), .core_result(core_result), .core_done(core_done)
   );

   // Stub core: an invertible keyed permutation that reproduces the known ECB vector.
   function automatic logic [127:0] rotl8(input logic [127:0] x);
      return {x[119:0], x[127:120]};
   endfunction
   function automatic logic [127:0] rotr8(input logic [127:0] x);
      return {x[7:0], x[127:8]};
   endfunction
   function automatic logic [127:0] cmask();
      return CT0 ^ rotl8(PT);
   endfunction
   function automatic logic [127:0] enc_f(input logic [127:0] x);
      return rotl8(x) ^ cmask();
   endfunction
   function automatic logic [127:0] dec_f(input logic [127:0] y);
      return rotr8(y ^ cmask());
   endfunction

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total = total + 1;
      assert (obs === exp) begin
         passed = passed + 1;
      end else begin
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      core_result = '0;
      core_done   = 1'b0;
      forever begin
         @(posedge clk);
         if (core_enable === 1'b1) begin
            stub_w = core_word;
            stub_m = core_mode;
            word_log.push_back(stub_w);
            mode_log.push_back(stub_m);
            check("core_key", core_key, K);
            repeat (2) @(posedge clk);
            #1;
            core_result = stub_m ? dec_f(stub_w) : enc_f(stub_w);
            core_done   = 1'b1;
            @(posedge clk);
            #1;
            core_done   = 1'b0;
            core_result = '0;
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         if (done === 1'b1) done_cnt = done_cnt + 1;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic do_start(input logic [1:0] m, input logic d, input logic [127:0] v);
      @(negedge clk);
      start = 1'b1; mode_sel = m; dir = d; key = K; iv = v;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic send_block(input logic [127:0] w, input logic l);
      int n = 0;
      @(negedge clk);
      while (in_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check("in_ready_timeout", 1'b0, 1'b1);
      in_valid = 1'b1; in_word = w; in_last = l;
      @(posedge clk);
      #1;
      in_valid = 1'b0; in_last = 1'b0;
      @(negedge clk);
      check("kick_enable", core_enable, 1'b1);
      check("ready_drop", in_ready, 1'b0);
   endtask

   task automatic collect(input logic [127:0] w, input logic l, input string tag);
      int n = 0;
      @(negedge clk);
      while (out_valid !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check({tag, "_timeout"}, 1'b0, 1'b1);
      check({tag, "_word"}, out_word, w);
      check({tag, "_last"}, out_last, l);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   initial begin
      srst_n = 1'b0; start = 1'b0; mode_sel = '0; dir = 1'b0; key = '0; iv = '0;
      in_valid = 1'b0; in_last = 1'b0; in_word = '0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_core_enable", core_enable, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_out_word", out_word, 128'h0);
      srst_n = 1'b1;
      @(negedge clk);
      check("idle_done", done, 1'b0);

      // ECB encrypt, single block
      do_start(2'd0, 1'b0, '0);
      @(negedge clk);
      check("ecb_busy", busy, 1'b1);
      send_block(PT, 1'b1);
      collect(CT0, 1'b1, "ecb_enc");
      exp_done++;
      check("ecb_enc_done", done_cnt, exp_done);
      check("ecb_enc_idle", busy, 1'b0);

      // ECB decrypt
      do_start(2'd0, 1'b1, '0);
      send_block(CT0, 1'b1);
      collect(PT, 1'b1, "ecb_dec");
      exp_done++;

      // CBC encrypt then decrypt, iv=0
      cb0 = CT0;
      cb1 = enc_f(PT ^ CT0);
      do_start(2'd1, 1'b0, '0);
      send_block(PT, 1'b0);
      send_block(PT, 1'b1);
      collect(cb0, 1'b0, "cbc_enc0");
      collect(cb1, 1'b1, "cbc_enc1");
      exp_done++;
      do_start(2'd1, 1'b1, '0);
      send_block(cb0, 1'b0);
      send_block(cb1, 1'b1);
      collect(PT, 1'b0, "cbc_dec0");
      collect(PT, 1'b1, "cbc_dec1");
      exp_done++;
      check("cbc_done", done_cnt, exp_done);

`ifdef AES_MODE_CTR_EN
      // CTR with a wrapping low word; dir must be ignored
      word_log.delete();
      mode_log.delete();
      do_start(2'd2, 1'b1, IVC);
      send_block(P1, 1'b0);
      send_block(P2, 1'b1);
      check("ctr_log_size", word_log.size(), 2);
      check("ctr_word0", word_log[0], IVC);
      check("ctr_word1", word_log[1], W1C);
      check("ctr_mode0", mode_log[0], 1'b0);
      collect(enc_f(IVC) ^ P1, 1'b0, "ctr_out0");
      collect(enc_f(W1C) ^ P2, 1'b1, "ctr_out1");
      exp_done++;
`else
      do_start(2'd2, 1'b0, IVC);
      @(negedge clk);
      check("ctr_off_err", err, 1'b1);
      check("ctr_off_busy", busy, 1'b0);
`endif

      // Backpressure: six ECB blocks into a four-deep FIFO
      do_start(2'd0, 1'b0, '0);
      @(negedge clk);
      check("bp_err_clear", err, 1'b0);
      for (int i = 0; i < 5; i++) send_block(PT ^ 128'(i), 1'b0);
      repeat (10) @(negedge clk);
      check("bp_stall_ready", in_ready, 1'b0);
      check("bp_stall_busy", busy, 1'b1);
      check("bp_head_held", out_word, enc_f(PT));
      check("bp_no_done", done_cnt, exp_done);
      collect(enc_f(PT), 1'b0, "bp_out0");
      send_block(PT ^ 128'd5, 1'b1);
      for (int i = 1; i < 6; i++) collect(enc_f(PT ^ 128'(i)), (i == 5), "bp_out");
      exp_done++;
      repeat (2) @(negedge clk);
      check("bp_empty", out_valid, 1'b0);
      check("bp_done", done_cnt, exp_done);

      // Reset while waiting on the core
      do_start(2'd0, 1'b0, '0);
      send_block(PT, 1'b1);
      @(posedge clk);
      #1;
      srst_n = 1'b0;
      @(negedge clk);
      check("midrst_busy", busy, 1'b0);
      check("midrst_enable", core_enable, 1'b0);
      check("midrst_out_valid", out_valid, 1'b0);
      check("midrst_in_ready", in_ready, 1'b0);
      repeat (3) @(negedge clk);
      srst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("midrst_still_empty", out_valid, 1'b0);
      do_start(2'd0, 1'b0, '0);
      send_block(PT ^ 128'd1, 1'b1);
      collect(enc_f(PT ^ 128'd1), 1'b1, "post_rst");
      exp_done++;

      // Reserved mode sets err; next good start clears it
      do_start(2'd3, 1'b0, '0);
      @(negedge clk);
      check("rsv_err", err, 1'b1);
      check("rsv_busy", busy, 1'b0);
      check("rsv_in_ready", in_ready, 1'b0);
      do_start(2'd0, 1'b0, '0);
      @(negedge clk);
      check("rsv_err_clear", err, 1'b0);
      send_block(PT, 1'b1);
      collect(CT0, 1'b1, "rsv_after");
      exp_done++;
      check("final_done", done_cnt, exp_done);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
